// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the fpcvt datapath and its arbiter.
// fp8_t packs sign, 3-bit exponent and 4-bit fraction.
package fpcvt_pkg;

  localparam int FP_D_W = 12;
  localparam int FP_E_W = 3;
  localparam int FP_F_W = 4;

  typedef struct packed {
    logic              s;
    logic [FP_E_W-1:0] e;
    logic [FP_F_W-1:0] f;
  } fp8_t;

  localparam fp8_t FP8_POS_SAT = 8'b0_111_1111;
  localparam fp8_t FP8_NEG_SAT = 8'b1_111_1111;

endpackage

// File: rtl/fpcvt.sv
// Combinational 12-bit two's-complement to S/E/F converter.
// Value ~= F * 2^E, round-to-nearest, saturating at E=7/F=15.
module fpcvt
  import fpcvt_pkg::*;
(
  input  logic [FP_D_W-1:0] d,
  output logic              s,
  output logic [FP_E_W-1:0] e,
  output logic [FP_F_W-1:0] f
);

  logic [FP_D_W-1:0] mag;
  logic [3:0]        msb;
  logic [3:0]        ex;
  logic [3:0]        fr;
  logic              rb;
  logic [4:0]        sum;
  fp8_t              res;

  always_comb begin
    mag = d[11] ? (~d + 12'd1) : d;
    msb = '0;
    for (int i = 0; i < 11; i++) begin
      if (mag[i]) msb = 4'(i);
    end
    ex  = (msb < 4'd4) ? 4'd0 : msb - 4'd3;
    fr  = 4'(mag >> ex);
    rb  = (ex != 4'd0) ? mag[ex - 4'd1] : 1'b0;
    sum = {1'b0, fr} + {4'b0, rb};
    if (sum[4]) begin
      fr = 4'b1000;
      ex = ex + 4'd1;
    end else begin
      fr = sum[3:0];
    end
    res = '{s: d[11], e: ex[2:0], f: fr};
    // -2048 has no positive magnitude; it and exponent overflow clamp
    if (mag[11] || ex > 4'd7)
      res = d[11] ? FP8_NEG_SAT : FP8_POS_SAT;
  end

  assign s = res.s;
  assign e = res.e;
  assign f = res.f;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr, wraps modulo N.
// ptr advances past the winner only when a grant is issued.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] idx;
  logic [PW-1:0] nxt;
  logic          found;

  always_comb begin
    grant = '0;
    nxt   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = en;
        nxt        = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en && |req)
      ptr <= nxt;
  end

endmodule

// File: rtl/fpcvt_arbiter.sv
// N_REQ requesters share one fpcvt through a 2-stage valid/ready pipe.
// Optional FPCVT_ARB_STATS_EN adds conv_count/sat_count outputs.
module fpcvt_arbiter
  import fpcvt_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [FP_D_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_s,
  output logic [FP_E_W-1:0]       out_e,
  output logic [FP_F_W-1:0]       out_f
`ifdef FPCVT_ARB_STATS_EN
  ,
  output logic [15:0]             conv_count,
  output logic [15:0]             sat_count
`endif
);

  logic              a_valid;
  logic [FP_D_W-1:0] a_data;
  logic [ID_W-1:0]   a_id;
  logic              b_load;
  logic              a_free;
  logic              arb_en;
  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   g_id;
  logic [FP_D_W-1:0] g_data;
  fp8_t              conv;
  fp8_t              b_q;

  assign b_load = a_valid & (!out_valid | out_ready);
  assign a_free = !a_valid | b_load;
  assign arb_en = a_free & !rst;
  assign accept = |grant;

  assign req_ready = grant;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant),
    .ptr   (rr_ptr)
  );

  always_comb begin
    g_id   = '0;
    g_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        g_id   = ID_W'(i);
        g_data = req_data[FP_D_W*i +: FP_D_W];
      end
    end
  end

  fpcvt u_cvt (
    .d (a_data),
    .s (conv.s),
    .e (conv.e),
    .f (conv.f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_id    <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_data  <= g_data;
      a_id    <= g_id;
    end else if (b_load) begin
      a_valid <= 1'b0;
    end
  end

  // B only changes on load or drain, so it holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      b_q       <= '0;
    end else if (b_load) begin
      out_valid <= 1'b1;
      out_id    <= a_id;
      b_q       <= conv;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_s = b_q.s;
  assign out_e = b_q.e;
  assign out_f = b_q.f;

`ifdef FPCVT_ARB_STATS_EN
  logic hs;
  logic is_sat;

  assign hs     = out_valid & out_ready;
  assign is_sat = (b_q.e == 3'b111) && (b_q.f == 4'b1111);

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_count <= '0;
      sat_count  <= '0;
    end else if (hs) begin
      if (conv_count != 16'hFFFF)
        conv_count <= conv_count + 16'd1;
      if (is_sat && sat_count != 16'hFFFF)
        sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
